// File: rtl/mcycle_seq.sv
// ============================================================================
// Module   : mcycle_seq
// Brief    : SM83 M-cycle sequencer. Fetches opcodes (and the CB second byte),
//            hands them to decode for one cycle, then walks immediate, data
//            read/write and internal cycles before strobing execute commit.
//            Also owns HALT and its interrupt wake-up.
// Options  : MCYCLE_SEQ_PERF_CNT_EN adds perf_cycles / perf_instrs counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcycle_seq #(
  parameter logic [7:0] IR_RESET  = 8'h00,
  parameter int         INT_CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic                 bus_sel,
  input  logic                 bus_ready,
  input  logic [7:0]           bus_rdata,
  output logic [7:0]           ir,
  output logic                 ir_cb,
  output logic [15:0]          imm,
  output logic [7:0]           mem_rdata,
  output logic                 pc_inc,
  input  logic                 dec_is_instr16,
  input  logic                 dec_halt,
  input  logic [1:0]           dec_imm_bytes,
  input  logic                 dec_mem_rd,
  input  logic                 dec_mem_wr,
  input  logic [INT_CNT_W-1:0] dec_int_cycles,
  output logic                 exec_stb,
  input  logic                 irq_pending,
  output logic                 halted
`ifdef MCYCLE_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]          perf_cycles,
  output logic [31:0]          perf_instrs
`endif
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_CB_FETCH = 4'd2;
  localparam logic [3:0] S_IMM_LO   = 4'd3;
  localparam logic [3:0] S_IMM_HI   = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_INTERNAL = 4'd7;
  localparam logic [3:0] S_EXEC     = 4'd8;
  localparam logic [3:0] S_HALT     = 4'd9;

  localparam logic [INT_CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [INT_CNT_W-1:0] CNT_ONE  = {{(INT_CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]           state_q, state_d;
  logic [7:0]           ir_q, ir_d;
  logic                 ir_cb_q, ir_cb_d;
  logic [15:0]          imm_q, imm_d;
  logic [7:0]           mem_rdata_q, mem_rdata_d;
  logic [1:0]           imm_bytes_q, imm_bytes_d;
  logic                 mem_rd_q, mem_rd_d;
  logic                 mem_wr_q, mem_wr_d;
  logic [INT_CNT_W-1:0] int_cycles_q, int_cycles_d;
  logic [INT_CNT_W-1:0] int_cnt_q, int_cnt_d;
  logic                 halted_q, halted_d;

  logic                 bus_state;
  logic                 bus_done;

  // Tail of the decode priority list starting at the data-read step.
  function automatic logic [3:0] after_imm(input logic rd, input logic wr,
                                           input logic [INT_CNT_W-1:0] ic);
    if (rd)                  return S_MEM_RD;
    else if (wr)             return S_MEM_WR;
    else if (ic != CNT_ZERO) return S_INTERNAL;
    else                     return S_EXEC;
  endfunction

  // Tail of the decode priority list starting at the internal-cycle step.
  function automatic logic [3:0] after_mem(input logic [INT_CNT_W-1:0] ic);
    if (ic != CNT_ZERO) return S_INTERNAL;
    else                return S_EXEC;
  endfunction

  // Bus strobes come straight from the state; reset forces the request low so
  // a pending access is abandoned and a late bus_ready has no effect.
  always_comb begin
    bus_state = (state_q == S_FETCH)  || (state_q == S_CB_FETCH) ||
                (state_q == S_IMM_LO) || (state_q == S_IMM_HI)   ||
                (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    bus_req   = bus_state & ~rst;
    bus_sel   = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    bus_we    = (state_q == S_MEM_WR);
    bus_done  = bus_req & bus_ready;
    pc_inc    = bus_done & ~bus_sel;
    exec_stb  = (state_q == S_EXEC) & ~rst;
  end

  // Next-state and datapath-capture logic for the M-cycle walk.
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    ir_cb_d      = ir_cb_q;
    imm_d        = imm_q;
    mem_rdata_d  = mem_rdata_q;
    imm_bytes_d  = imm_bytes_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_d     = mem_wr_q;
    int_cycles_d = int_cycles_q;
    int_cnt_d    = int_cnt_q;
    halted_d     = halted_q;

    case (state_q)
      S_FETCH: begin
        if (bus_done) begin
          ir_d    = bus_rdata;
          ir_cb_d = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        imm_bytes_d  = dec_imm_bytes;
        mem_rd_d     = dec_mem_rd;
        mem_wr_d     = dec_mem_wr;
        int_cycles_d = dec_int_cycles;
        if (dec_halt) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (dec_is_instr16 && !ir_cb_q) begin
          state_d = S_CB_FETCH;
        end else if (dec_imm_bytes != 2'd0) begin
          state_d = S_IMM_LO;
        end else begin
          state_d = after_imm(dec_mem_rd, dec_mem_wr, dec_int_cycles);
        end
      end
      S_CB_FETCH: begin
        if (bus_done) begin
          ir_d    = bus_rdata;
          ir_cb_d = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_IMM_LO: begin
        if (bus_done) begin
          imm_d = {8'h00, bus_rdata};
          // An encoding of 3 behaves like 2 bytes.
          if (imm_bytes_q >= 2'd2) state_d = S_IMM_HI;
          else                     state_d = after_imm(mem_rd_q, mem_wr_q, int_cycles_q);
        end
      end
      S_IMM_HI: begin
        if (bus_done) begin
          imm_d[15:8] = bus_rdata;
          state_d     = after_imm(mem_rd_q, mem_wr_q, int_cycles_q);
        end
      end
      S_MEM_RD: begin
        if (bus_done) begin
          mem_rdata_d = bus_rdata;
          if (mem_wr_q) state_d = S_MEM_WR;
          else          state_d = after_mem(int_cycles_q);
        end
      end
      S_MEM_WR: begin
        if (bus_done) state_d = after_mem(int_cycles_q);
      end
      S_INTERNAL: begin
        if (int_cnt_q <= CNT_ONE) state_d = S_EXEC;
        else                      int_cnt_d = int_cnt_q - CNT_ONE;
      end
      S_EXEC: begin
        ir_cb_d = 1'b0;
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (irq_pending) begin
          halted_d = 1'b0;
          state_d  = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    // The internal-cycle counter is loaded on entry; from DECODE the freshly
    // decoded count is used since the sampled copy is not yet registered.
    if ((state_d == S_INTERNAL) && (state_q != S_INTERNAL)) begin
      if (state_q == S_DECODE) int_cnt_d = dec_int_cycles;
      else                     int_cnt_d = int_cycles_q;
    end
  end

  // Sequencer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      ir_q         <= IR_RESET;
      ir_cb_q      <= 1'b0;
      imm_q        <= 16'h0000;
      mem_rdata_q  <= 8'h00;
      imm_bytes_q  <= 2'd0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      int_cycles_q <= CNT_ZERO;
      int_cnt_q    <= CNT_ZERO;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      ir_cb_q      <= ir_cb_d;
      imm_q        <= imm_d;
      mem_rdata_q  <= mem_rdata_d;
      imm_bytes_q  <= imm_bytes_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      int_cycles_q <= int_cycles_d;
      int_cnt_q    <= int_cnt_d;
      halted_q     <= halted_d;
    end
  end

  assign ir        = ir_q;
  assign ir_cb     = ir_cb_q;
  assign imm       = imm_q;
  assign mem_rdata = mem_rdata_q;
  assign halted    = halted_q;

`ifdef MCYCLE_SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles_q;
  logic [31:0] perf_instrs_q;

  // Free-running cycle and retired-instruction counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles_q <= 32'd0;
      perf_instrs_q <= 32'd0;
    end else begin
      if (!halted_q) perf_cycles_q <= perf_cycles_q + 32'd1;
      if (exec_stb)  perf_instrs_q <= perf_instrs_q + 32'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_instrs = perf_instrs_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mcycle_seq.sv
// ============================================================================
// Module   : tb_mcycle_seq
// Brief    : Scoreboard bench for mcycle_seq. A bus responder serves bytes
//            from a queue; a monitor compares each exec_stb against the
//            expected instruction record.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcycle_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_req, bus_we, bus_sel;
  logic        bus_ready = 1'b0;
  logic [7:0]  bus_rdata = 8'h00;
  logic [7:0]  ir;
  logic        ir_cb;
  logic [15:0] imm;
  logic [7:0]  mem_rdata;
  logic        pc_inc;
  logic        dec_is_instr16, dec_halt, dec_mem_rd, dec_mem_wr;
  logic [1:0]  dec_imm_bytes;
  logic [2:0]  dec_int_cycles;
  logic        exec_stb;
  logic        irq_pending = 1'b0;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  typedef struct { logic [7:0] d; int w; } mem_t;
  typedef struct {
    logic [7:0]  ir;
    logic        cb;
    logic [15:0] imm;
    logic [7:0]  mrd;
    int          len;
    int          pci;
    int          rdc;
    int          wrc;
  } exp_t;

  mem_t memq[$];
  exp_t sb[$];

  logic fire_q    = 1'b0;
  logic force_rdy = 1'b0;
  logic stall     = 1'b0;
  int   wcnt      = 0;
  int   pci_total = 0;

  mcycle_seq #(.IR_RESET(8'h00), .INT_CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .ir(ir), .ir_cb(ir_cb), .imm(imm), .mem_rdata(mem_rdata), .pc_inc(pc_inc),
    .dec_is_instr16(dec_is_instr16), .dec_halt(dec_halt),
    .dec_imm_bytes(dec_imm_bytes), .dec_mem_rd(dec_mem_rd),
    .dec_mem_wr(dec_mem_wr), .dec_int_cycles(dec_int_cycles),
    .exec_stb(exec_stb), .irq_pending(irq_pending), .halted(halted)
  );

  always #5 clk = ~clk;

  // Small decode model covering the opcodes used below.
  always_comb begin
    dec_is_instr16 = (ir == 8'hCB);
    dec_halt       = 1'b0;
    dec_imm_bytes  = 2'd0;
    dec_mem_rd     = 1'b0;
    dec_mem_wr     = 1'b0;
    dec_int_cycles = 3'd0;
    if (!ir_cb) begin
      case (ir)
        8'h01: dec_imm_bytes = 2'd2;
        8'h02: begin dec_imm_bytes = 2'd3; dec_mem_wr = 1'b1; end
        8'h03: dec_int_cycles = 3'd3;
        8'h18: begin dec_imm_bytes = 2'd1; dec_int_cycles = 3'd1; end
        8'h34: begin dec_mem_rd = 1'b1; dec_mem_wr = 1'b1; end
        8'h76: dec_halt = 1'b1;
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Completed-access and pc_inc bookkeeping from pre-edge values.
  always @(posedge clk) begin
    fire_q    <= bus_req & bus_ready;
    pci_total <= pci_total + (pc_inc ? 1 : 0);
  end

  // Bus responder: one queue entry per access, with per-entry wait states.
  always @(negedge clk) begin
    if (fire_q) begin
      if (memq.size() > 0) void'(memq.pop_front());
      wcnt = 0;
    end
    if (rst) begin
      bus_ready = force_rdy;
      bus_rdata = 8'hEE;
      wcnt      = 0;
      stall     = 1'b0;
    end else if (bus_req && memq.size() > 0) begin
      stall = 1'b0;
      if (wcnt >= memq[0].w) begin
        bus_ready = 1'b1;
        bus_rdata = memq[0].d;
      end else begin
        bus_ready = 1'b0;
        bus_rdata = 8'hEE;
        wcnt++;
      end
    end else begin
      bus_ready = 1'b0;
      bus_rdata = 8'hEE;
      stall     = bus_req;
    end
  end

  // Monitor: counts per-instruction cycles and checks each exec_stb.
  initial begin
    int len = 0, pci = 0, rdc = 0, wrc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        len = 0; pci = 0; rdc = 0; wrc = 0;
      end else begin
        if (!stall) len++;
        if (pc_inc) pci++;
        if (bus_req && bus_sel && !bus_we) rdc++;
        if (bus_req && bus_sel && bus_we)  wrc++;
        if (exec_stb) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_exec actual=1 required=0 ir=%0h", ir);
          end else begin
            e = sb.pop_front();
            chk("exec_ir",        ir,        e.ir);
            chk("exec_ir_cb",     ir_cb,     e.cb);
            chk("exec_imm",       imm,       e.imm);
            chk("exec_mem_rdata", mem_rdata, e.mrd);
            if (e.len >= 0) chk("exec_len", len, e.len);
            chk("exec_pc_inc",    pci,       e.pci);
            chk("exec_rd_cycles", rdc,       e.rdc);
            chk("exec_wr_cycles", wrc,       e.wrc);
          end
          len = 0; pci = 0; rdc = 0; wrc = 0;
        end
      end
    end
  end

  task automatic mem(input logic [7:0] d, input int w);
    mem_t m;
    m.d = d; m.w = w;
    memq.push_back(m);
  endtask

  task automatic expect_i(input logic [7:0] i, input logic cb, input logic [15:0] im,
                          input logic [7:0] mr, input int len, input int pci,
                          input int rdc, input int wrc);
    exp_t e;
    e.ir = i; e.cb = cb; e.imm = im; e.mrd = mr;
    e.len = len; e.pci = pci; e.rdc = rdc; e.wrc = wrc;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=pending required=done", name);
      sb.delete();
      memq.delete();
    end
  endtask

  initial begin
    int n;
    int base;
    logic bad;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_bus_req",   bus_req,   1'b0);
    chk("rst_exec_stb",  exec_stb,  1'b0);
    chk("rst_halted",    halted,    1'b0);
    chk("rst_ir",        ir,        8'h00);
    chk("rst_ir_cb",     ir_cb,     1'b0);
    chk("rst_imm",       imm,       16'h0000);
    chk("rst_mem_rdata", mem_rdata, 8'h00);
    rst = 1'b0;
    @(posedge clk); #2;
    chk("fetch_after_rst", bus_req, 1'b1);

    // NOP, zero wait
    expect_i(8'h00, 1'b0, 16'h0000, 8'h00, 3, 1, 0, 0);
    mem(8'h00, 0);
    drain("nop");

    // LD BC,d16 with two wait states per access
    expect_i(8'h01, 1'b0, 16'h1234, 8'h00, 11, 3, 0, 0);
    mem(8'h01, 2); mem(8'h34, 2); mem(8'h12, 2);
    drain("ld_bc");

    // CB 37
    expect_i(8'h37, 1'b1, 16'h1234, 8'h00, 5, 2, 0, 0);
    mem(8'hCB, 0); mem(8'h37, 0);
    drain("cb37");
    chk("cb_clear_after_exec", ir_cb, 1'b0);

    // CB CB: prefix byte as second byte is not re-fetched
    expect_i(8'hCB, 1'b1, 16'h1234, 8'h00, 5, 2, 0, 0);
    mem(8'hCB, 0); mem(8'hCB, 0);
    drain("cbcb");

    // INC (HL): read-modify-write
    expect_i(8'h34, 1'b0, 16'h1234, 8'h7F, 5, 1, 1, 1);
    mem(8'h34, 0); mem(8'h7F, 0); mem(8'h00, 0);
    drain("inc_hl");

    // One immediate byte plus one internal cycle
    expect_i(8'h18, 1'b0, 16'h00FE, 8'h7F, 5, 2, 0, 0);
    mem(8'h18, 0); mem(8'hFE, 0);
    drain("jr");

    // Three internal cycles, captures held
    expect_i(8'h03, 1'b0, 16'h00FE, 8'h7F, 6, 1, 0, 0);
    mem(8'h03, 0);
    drain("int3");

    // imm_bytes = 3 behaves as 2, then a write with one wait state
    expect_i(8'h02, 1'b0, 16'hABCD, 8'h7F, 7, 3, 0, 2);
    mem(8'h02, 0); mem(8'hCD, 0); mem(8'hAB, 0); mem(8'h00, 1);
    drain("imm3_wr");

    // HALT and interrupt wake-up
    mem(8'h76, 0);
    n = 0;
    while (!halted && n < 50) begin @(posedge clk); #2; n++; end
    chk("halt_entered", halted, 1'b1);
    expect_i(8'h00, 1'b0, 16'hABCD, 8'h7F, -1, 2, 0, 0);
    mem(8'h00, 0);
    bad = 1'b0;
    repeat (10) begin
      @(posedge clk); #2;
      if (!halted || bus_req) bad = 1'b1;
    end
    chk("halt_hold", bad, 1'b0);
    irq_pending = 1'b1;
    @(posedge clk); #2;
    chk("wake_bus_req", bus_req, 1'b1);
    chk("wake_halted",  halted,  1'b0);
    irq_pending = 1'b0;
    drain("after_halt");

    // Reset during an IMM_HI wait state
    base = pci_total;
    mem(8'h01, 3); mem(8'h34, 3); mem(8'h12, 3);
    n = 0;
    while (pci_total != base + 2 && n < 100) begin @(posedge clk); #2; n++; end
    chk("imm_hi_reached", pci_total - base, 2);
    rst = 1'b1;
    force_rdy = 1'b1;
    @(posedge clk); #2;
    chk("midrst_bus_req", bus_req, 1'b0);
    chk("midrst_imm",     imm,     16'h0000);
    chk("midrst_ir",      ir,      8'h00);
    @(negedge clk); #2;
    chk("midrst_late_ready_pc_inc", pc_inc, 1'b0);
    chk("midrst_late_ready_req",    bus_req, 1'b0);
    @(posedge clk); #2;
    memq.delete();
    force_rdy = 1'b0;
    rst = 1'b0;
    expect_i(8'h00, 1'b0, 16'h0000, 8'h00, 3, 1, 0, 0);
    mem(8'h00, 0);
    drain("nop_after_rst");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
